// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank writeback path.
package regbank_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        PORT_ALU  = 1'b0,
        PORT_LOAD = 1'b1
    } wb_port_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; writes to register 0 are accepted but never stored.
module wb_slot #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              ready,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              load
);

    // A slot being drained this cycle can take a new request on the same edge.
    assign ready = !full || grant;
    assign load  = in_valid && ready && (in_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= in_addr;
            data <= in_data;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates the ALU and load writeback slots onto the single register-bank write port,
// preserving same-register order and exposing a pending-register bitmap.
module regbank_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              regwrite,
    output logic [ADDR_W-1:0] register3,
    output logic [DATA_W-1:0] datain,
    output logic [31:0]       pending,
    output logic [CNT_W-1:0]  stall_cnt
);

    import regbank_pkg::*;

    logic              full0, full1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              load0, load1;
    logic              grant0, grant1;
    logic              age1;
    wb_port_e          last_grant;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (req0_valid),
        .in_addr  (req0_addr),
        .in_data  (req0_data),
        .grant    (grant0),
        .ready    (req0_ready),
        .full     (full0),
        .addr     (addr0),
        .data     (data0),
        .load     (load0)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (req1_valid),
        .in_addr  (req1_addr),
        .in_data  (req1_data),
        .grant    (grant1),
        .ready    (req1_ready),
        .full     (full1),
        .addr     (addr1),
        .data     (data1),
        .load     (load1)
    );

    // Same-register writes go oldest first; otherwise alternate between the ports.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0 && full1) begin
            if (addr0 == addr1) begin
                if (age1) grant1 = 1'b1;
                else      grant0 = 1'b1;
            end else if (last_grant == PORT_LOAD) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (full0) begin
            grant0 = 1'b1;
        end else if (full1) begin
            grant1 = 1'b1;
        end
    end

    always_comb begin
        regwrite  = grant0 || grant1;
        register3 = '0;
        datain    = '0;
        if (grant0) begin
            register3 = addr0;
            datain    = data0;
        end else if (grant1) begin
            register3 = addr1;
            datain    = data1;
        end
    end

    always_comb begin
        pending = '0;
        if (full0) pending = pending | (NUM_REGS'(1) << addr0);
        if (full1) pending = pending | (NUM_REGS'(1) << addr1);
    end

    // age1 is set when slot 1 holds the older entry; a simultaneous load makes port 0 older.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age1 <= 1'b0;
        end else if (load0 && load1) begin
            age1 <= 1'b0;
        end else if (load0) begin
            age1 <= full1 && !grant1;
        end else if (load1) begin
            age1 <= !(full0 && !grant0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_LOAD;
        end else if (grant0) begin
            last_grant <= PORT_ALU;
        end else if (grant1) begin
            last_grant <= PORT_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (full0 && full1 && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: vector table, hand-written ordering/reset sequences,
// and a scoreboard of expected bank writes.
module tb_regbank_write_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          regwrite;
    logic [AW-1:0] register3;
    logic [DW-1:0] datain;
    logic [31:0]   pending;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    regbank_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .regwrite   (regwrite),
        .register3  (register3),
        .datain     (datain),
        .pending    (pending),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        bit            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            exp_wr;
        logic [31:0]   exp_pend;
    } vec_t;

    wr_t           sb[$];
    vec_t          vecs[6];
    logic [DW-1:0] bank[32] = '{default: '0};
    int            n_checks = 0;
    int            n_fail = 0;

    logic [AW-1:0] s0_addr[32];
    logic [AW-1:0] s1_addr[32];
    logic [DW-1:0] s0_data[32];
    logic [DW-1:0] s1_data[32];
    logic          log_r0[32];
    logic          log_r1[32];
    logic [CW-1:0] log_st[32];

    bit            exp_r0[8] = '{1, 1, 0, 1, 0, 1, 1, 1};
    bit            exp_r1[8] = '{1, 0, 1, 0, 1, 0, 1, 1};
    int            exp_st[8] = '{0, 0, 1, 2, 3, 4, 5, 5};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
    endtask

    task automatic pushExp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic resetAndCheck();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("rst_regwrite", 64'(regwrite), 64'd0);
        checkOutput("rst_register3", 64'(register3), 64'd0);
        checkOutput("rst_datain", datain, 64'd0);
        checkOutput("rst_pending", 64'(pending), 64'd0);
        checkOutput("rst_ready0", 64'(req0_ready), 64'd1);
        checkOutput("rst_ready1", 64'(req1_ready), 64'd1);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
    endtask

    // Both ports stream n items; the write order alternates starting with port 0 after reset.
    task automatic runStream(input int n, input int ncyc);
        int i0 = 0;
        int i1 = 0;
        bit t0 = 1'b0;
        bit t1 = 1'b0;
        for (int k = 0; k < n; k++) begin
            pushExp(s0_addr[k], s0_data[k]);
            pushExp(s1_addr[k], s1_data[k]);
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (t0) i0++;
            if (t1) i1++;
            log_r0[c] = req0_ready;
            log_r1[c] = req1_ready;
            log_st[c] = stall_cnt;
            applyStimulus(i0 < n, s0_addr[i0], s0_data[i0], i1 < n, s1_addr[i1], s1_data[i1]);
            t0 = (i0 < n) && (req0_ready === 1'b1);
            t1 = (i1 < n) && (req1_ready === 1'b1);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Scoreboard: sample the bank port mid-cycle, commit on the edge unless reset intervened.
    logic          cap_w = 1'b0;
    logic [AW-1:0] cap_a = '0;
    logic [DW-1:0] cap_d = '0;

    always @(negedge clk) begin
        cap_w = regwrite;
        cap_a = register3;
        cap_d = datain;
    end

    always @(posedge clk) begin
        if (cap_w === 1'b1 && !rst) begin
            wr_t e;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL sb_unexpected: bank write reg %0d data 0x%0h, required none", cap_a, cap_d);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_addr", 64'(cap_a), 64'(e.addr));
                checkOutput("sb_data", cap_d, e.data);
            end
        end
    end

    always @(posedge clk) begin
        if (regwrite === 1'b1) bank[register3] <= datain;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 5'd5,  64'h0000_0000_0000_DEAD, 1'b1, 32'h0000_0020};
        vecs[1] = '{1'b1, 5'd0,  64'h0000_0000_0000_FFFF, 1'b0, 32'h0000_0000};
        vecs[2] = '{1'b1, 5'd31, 64'h0123_4567_89AB_CDEF, 1'b1, 32'h8000_0000};
        vecs[3] = '{1'b0, 5'd0,  64'h0000_0000_0000_0055, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 5'd12, 64'hCAFE_F00D_0000_0001, 1'b1, 32'h0000_1000};
        vecs[5] = '{1'b0, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'h0000_0002};

        $display("[TB] reset state");
        resetAndCheck();

        $display("[TB] single-request vectors");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("v%0d_ready", i),
                        64'(vecs[i].port ? req1_ready : req0_ready), 64'd1);
            if (vecs[i].port)
                applyStimulus(1'b0, '0, '0, 1'b1, vecs[i].addr, vecs[i].data);
            else
                applyStimulus(1'b1, vecs[i].addr, vecs[i].data, 1'b0, '0, '0);
            if (vecs[i].exp_wr) pushExp(vecs[i].addr, vecs[i].data);
            @(negedge clk);
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
            checkOutput($sformatf("v%0d_regwrite", i), 64'(regwrite), 64'(vecs[i].exp_wr));
            checkOutput($sformatf("v%0d_register3", i), 64'(register3),
                        vecs[i].exp_wr ? 64'(vecs[i].addr) : 64'd0);
            checkOutput($sformatf("v%0d_datain", i), datain, vecs[i].exp_wr ? vecs[i].data : 64'd0);
            checkOutput($sformatf("v%0d_pending", i), 64'(pending), 64'(vecs[i].exp_pend));
            @(negedge clk);
            checkOutput($sformatf("v%0d_pending_clear", i), 64'(pending), 64'd0);
            checkOutput($sformatf("v%0d_regwrite_clear", i), 64'(regwrite), 64'd0);
            checkOutput($sformatf("v%0d_bank", i), bank[vecs[i].addr],
                        vecs[i].exp_wr ? vecs[i].data : 64'd0);
        end

        $display("[TB] simultaneous same-register load, port 0 granted last");
        @(negedge clk);
        applyStimulus(1'b1, 5'd7, 64'hB0, 1'b1, 5'd7, 64'hA1);
        pushExp(5'd7, 64'hB0);
        pushExp(5'd7, 64'hA1);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("simul_first_addr", 64'(register3), 64'd7);
        checkOutput("simul_first_data", datain, 64'hB0);
        checkOutput("simul_ready1_held", 64'(req1_ready), 64'd0);
        @(negedge clk);
        checkOutput("simul_second_data", datain, 64'hA1);
        @(negedge clk);
        checkOutput("simul_bank7", bank[7], 64'hA1);
        checkOutput("simul_stall_cnt", 64'(stall_cnt), 64'd1);

        $display("[TB] same-register ordering behind a stalled slot");
        @(negedge clk);
        applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 64'hA);
        pushExp(5'd3, 64'h33);
        @(negedge clk);
        checkOutput("order_ready0", 64'(req0_ready), 64'd1);
        checkOutput("order_ready1", 64'(req1_ready), 64'd0);
        checkOutput("order_first_addr", 64'(register3), 64'd3);
        applyStimulus(1'b1, 5'd7, 64'hB, 1'b0, '0, '0);
        pushExp(5'd7, 64'hA);
        pushExp(5'd7, 64'hB);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("order_pending", 64'(pending), 64'h0000_0080);
        checkOutput("order_older_addr", 64'(register3), 64'd7);
        checkOutput("order_older_data", datain, 64'hA);
        @(negedge clk);
        checkOutput("order_newer_data", datain, 64'hB);
        @(negedge clk);
        checkOutput("order_idle", 64'(regwrite), 64'd0);
        checkOutput("order_bank7", bank[7], 64'hB);
        checkOutput("order_stall_cnt", 64'(stall_cnt), 64'd3);

        $display("[TB] asynchronous reset with both slots full");
        @(negedge clk);
        applyStimulus(1'b1, 5'd20, 64'h20, 1'b1, 5'd21, 64'h21);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("midrst_pending_before", 64'(pending), 64'h0030_0000);
        checkOutput("midrst_regwrite_before", 64'(regwrite), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_regwrite", 64'(regwrite), 64'd0);
        checkOutput("midrst_register3", 64'(register3), 64'd0);
        checkOutput("midrst_datain", datain, 64'd0);
        checkOutput("midrst_pending", 64'(pending), 64'd0);
        checkOutput("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready0_after", 64'(req0_ready), 64'd1);
        checkOutput("midrst_ready1_after", 64'(req1_ready), 64'd1);
        checkOutput("midrst_idle_after", 64'(regwrite), 64'd0);
        checkOutput("midrst_bank20", bank[20], 64'd0);
        checkOutput("midrst_bank21", bank[21], 64'd0);

        $display("[TB] round-robin streaming");
        resetAndCheck();
        for (int k = 0; k < 3; k++) begin
            s0_addr[k] = AW'(1 + k);
            s1_addr[k] = AW'(9 + k);
            s0_data[k] = 64'hA0A0_0000_0000_0000 + 64'(k);
            s1_data[k] = 64'hB1B1_0000_0000_0000 + 64'(k);
        end
        runStream(3, 8);
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("rr_ready0_c%0d", c), 64'(log_r0[c]), 64'(exp_r0[c]));
            checkOutput($sformatf("rr_ready1_c%0d", c), 64'(log_r1[c]), 64'(exp_r1[c]));
            checkOutput($sformatf("rr_stall_c%0d", c), 64'(log_st[c]), 64'(exp_st[c]));
        end
        checkOutput("rr_bank3", bank[3], 64'hA0A0_0000_0000_0002);
        checkOutput("rr_bank11", bank[11], 64'hB1B1_0000_0000_0002);

        $display("[TB] stall counter saturation");
        resetAndCheck();
        for (int k = 0; k < 12; k++) begin
            s0_addr[k] = 5'd4;
            s1_addr[k] = 5'd8;
            s0_data[k] = 64'hC0C0_0000_0000_0000 + 64'(k);
            s1_data[k] = 64'hD1D1_0000_0000_0000 + 64'(k);
        end
        runStream(12, 28);
        for (int c = 1; c < 28; c++) begin
            checkOutput($sformatf("sat_stall_c%0d", c), 64'(log_st[c]),
                        64'(((c - 1) > 15) ? 15 : (c - 1)));
        end
        @(negedge clk);
        checkOutput("sat_stall_final", 64'(stall_cnt), 64'd15);
        checkOutput("sat_bank4", bank[4], 64'hC0C0_0000_0000_000B);
        checkOutput("sat_bank8", bank[8], 64'hD1D1_0000_0000_000B);

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
